// File: rtl/song_sequencer.sv
// Programmable multi-channel song sequencer: a writable step memory played back at a
// programmable tempo, with play/pause/stop control, loop mode and an end-of-song pulse.
module song_sequencer #(
    parameter int NUM_CH = 4,
    parameter int TONE_W = 4,
    parameter int ADDR_W = 8,
    parameter int DIV_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NUM_CH*TONE_W-1:0] wr_data,
    input  logic                     play,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic [DIV_W-1:0]         tempo_div,
    input  logic [ADDR_W-1:0]        song_len,
    output logic [NUM_CH*TONE_W-1:0] tones_out,
    output logic [ADDR_W-1:0]        step_index,
    output logic                     step_strobe,
    output logic                     busy,
    output logic                     done
);

    localparam int WORD_W = NUM_CH * TONE_W;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t             state;
    logic [DIV_W-1:0]   tick_cnt;
    logic [WORD_W-1:0]  tone_reg;
    logic [WORD_W-1:0]  mem [0:(1<<ADDR_W)-1];

    logic               step_end;
    logic               last_step;
    logic [ADDR_W-1:0]  next_idx;

    // Step memory is intentionally not reset so a song survives a system reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign step_end  = (tick_cnt == tempo_div);
    assign last_step = (step_index >= song_len);
    assign next_idx  = last_step ? '0 : step_index + 1'b1;
    assign busy      = (state != IDLE);

    // The cycle in which play arrives during RUN still counts as a RUN cycle, so a
    // pause freezes the tick count one cycle further on and resume picks up from there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            step_index  <= '0;
            tone_reg    <= '0;
            tones_out   <= '0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop) begin
                state      <= IDLE;
                tick_cnt   <= '0;
                step_index <= '0;
                tone_reg   <= '0;
                tones_out  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (play) begin
                            state       <= RUN;
                            tick_cnt    <= '0;
                            step_index  <= '0;
                            tone_reg    <= mem[0];
                            tones_out   <= mem[0];
                            step_strobe <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (step_end && last_step && !loop_en) begin
                            state      <= IDLE;
                            tick_cnt   <= '0;
                            step_index <= '0;
                            tone_reg   <= '0;
                            tones_out  <= '0;
                            done       <= 1'b1;
                        end else begin
                            if (step_end) begin
                                tick_cnt    <= '0;
                                step_index  <= next_idx;
                                tone_reg    <= mem[next_idx];
                                tones_out   <= mem[next_idx];
                                step_strobe <= !play;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                            // Pausing mutes the output but keeps the tone register for resume.
                            if (play) begin
                                state     <= PAUSE;
                                tones_out <= '0;
                            end
                        end
                    end
                    PAUSE: begin
                        if (play) begin
                            state     <= RUN;
                            tones_out <= tone_reg;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: a table of cycle vectors, hand-written corner
// sequences and a randomized run, all compared against a behavioural model of the song.
module tb_song_sequencer;

    localparam int NUM_CH = 4;
    localparam int TONE_W = 4;
    localparam int ADDR_W = 8;
    localparam int DIV_W  = 24;
    localparam int WORD_W = NUM_CH * TONE_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              play;
    logic              stop;
    logic              loop_en;
    logic [DIV_W-1:0]  tempo_div;
    logic [ADDR_W-1:0] song_len;
    logic [WORD_W-1:0] tones_out;
    logic [ADDR_W-1:0] step_index;
    logic              step_strobe;
    logic              busy;
    logic              done;

    always #5 clk = ~clk;

    song_sequencer #(
        .NUM_CH(NUM_CH), .TONE_W(TONE_W), .ADDR_W(ADDR_W), .DIV_W(DIV_W)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .play(play), .stop(stop), .loop_en(loop_en),
        .tempo_div(tempo_div), .song_len(song_len),
        .tones_out(tones_out), .step_index(step_index),
        .step_strobe(step_strobe), .busy(busy), .done(done)
    );

    int tests = 0;
    int failures = 0;

    // Behavioural song model: mode 0 = stopped, 1 = playing, 2 = paused.
    logic [WORD_W-1:0] ref_mem [0:255];
    int                ref_mode;
    int                ref_pos;
    int                ref_age;
    logic [WORD_W-1:0] ref_word;
    logic [WORD_W-1:0] exp_tones;
    logic [ADDR_W-1:0] exp_idx;
    logic              exp_strobe;
    logic              exp_busy;
    logic              exp_done;

    typedef struct {
        logic              play;
        logic [WORD_W-1:0] tones;
        logic [ADDR_W-1:0] idx;
        logic              strobe;
        logic              busy;
        logic              done;
    } vec_t;

    vec_t vecs [14];

    function void modelReset();
        ref_mode   = 0;
        ref_pos    = 0;
        ref_age    = 0;
        ref_word   = '0;
        exp_tones  = '0;
        exp_idx    = '0;
        exp_strobe = 1'b0;
        exp_busy   = 1'b0;
        exp_done   = 1'b0;
    endfunction

    function void modelUpdate();
        exp_strobe = 1'b0;
        exp_done   = 1'b0;
        if (stop) begin
            ref_mode = 0; ref_pos = 0; ref_age = 0; ref_word = '0;
        end else if (ref_mode == 0) begin
            if (play) begin
                ref_mode = 1; ref_pos = 0; ref_age = 0;
                ref_word = ref_mem[0];
                exp_strobe = 1'b1;
            end
        end else if (ref_mode == 1) begin
            if (ref_age == int'(tempo_div)) begin
                if (ref_pos >= int'(song_len) && !loop_en) begin
                    ref_mode = 0; ref_pos = 0; ref_age = 0; ref_word = '0;
                    exp_done = 1'b1;
                end else begin
                    ref_pos  = (ref_pos >= int'(song_len)) ? 0 : ref_pos + 1;
                    ref_age  = 0;
                    ref_word = ref_mem[ref_pos];
                    exp_strobe = !play;
                end
            end else begin
                ref_age++;
            end
            if (play && ref_mode == 1) ref_mode = 2;
        end else begin
            if (play) ref_mode = 1;
        end
        if (wr_en) ref_mem[wr_addr] = wr_data;
        exp_tones = (ref_mode == 1) ? ref_word : '0;
        exp_idx   = 8'(ref_pos);
        exp_busy  = (ref_mode != 0);
    endfunction

    task automatic checkOutput(input string name, input logic [WORD_W-1:0] e_tones,
                               input logic [ADDR_W-1:0] e_idx, input logic e_strobe,
                               input logic e_busy, input logic e_done);
        tests++;
        if (tones_out !== e_tones || step_index !== e_idx || step_strobe !== e_strobe ||
            busy !== e_busy || done !== e_done) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got tones=%h idx=%0d strobe=%b busy=%b done=%b, want tones=%h idx=%0d strobe=%b busy=%b done=%b",
                     name, $time, tones_out, step_index, step_strobe, busy, done,
                     e_tones, e_idx, e_strobe, e_busy, e_done);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic s, input logic w,
                                 input logic [ADDR_W-1:0] a, input logic [WORD_W-1:0] d);
        play    = p;
        stop    = s;
        wr_en   = w;
        wr_addr = a;
        wr_data = d;
    endtask

    // One clock: model follows the edge, outputs are compared 1 ns later.
    task automatic cycle();
        @(posedge clk);
        if (!reset) modelUpdate();
        #1;
        checkOutput("model", exp_tones, exp_idx, exp_strobe, exp_busy, exp_done);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        cycle();
    endtask

    initial begin
        int strobes;
        int dones;
        vecs[0]  = '{1'b1, 16'h1000, 8'd0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 16'h1000, 8'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 16'h1000, 8'd0, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 16'h0200, 8'd1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 16'h0200, 8'd1, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 16'h0200, 8'd1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 16'h0030, 8'd2, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 16'h0030, 8'd2, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 16'h0030, 8'd2, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 16'h0004, 8'd3, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 16'h0004, 8'd3, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 16'h0004, 8'd3, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0};

        modelReset();
        reset = 1'b1;
        loop_en = 1'b0; tempo_div = 24'd2; song_len = 8'd3;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        checkOutput("reset_state", '0, '0, 1'b0, 1'b0, 1'b0);
        cycle();
        cycle();
        reset = 1'b0;

        for (int a = 0; a < 16; a++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'(a), 16'($urandom));
            cycle();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 16'h1000); cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd1, 16'h0200); cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd2, 16'h0030); cycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd3, 16'h0004); cycle();

        // Plain four-step song, no loop.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].play, 1'b0, 1'b0, '0, '0);
            cycle();
            checkOutput("plan1_row", vecs[i].tones, vecs[i].idx, vecs[i].strobe,
                        vecs[i].busy, vecs[i].done);
        end

        // Pause mid-step 1, resume, then stop+play together during step 2.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0); cycle();
        for (int i = 0; i < 4; i++) idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0); cycle();
        checkOutput("plan3_paused", 16'h0000, 8'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            idleCycle();
            checkOutput("plan3_paused", 16'h0000, 8'd1, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0); cycle();
        checkOutput("plan3_resume", 16'h0200, 8'd1, 1'b0, 1'b1, 1'b0);
        idleCycle();
        checkOutput("plan3_step2", 16'h0030, 8'd2, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0, '0); cycle();
        checkOutput("plan4_stop", 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0);
        idleCycle();
        checkOutput("plan4_no_done", 16'h0000, 8'd0, 1'b0, 1'b0, 1'b0);

        // Loop mode: three full passes, no done pulse.
        loop_en = 1'b1;
        strobes = 0; dones = 0;
        for (int i = 0; i < 36; i++) begin
            applyStimulus(i == 0, 1'b0, 1'b0, '0, '0);
            cycle();
            if (step_strobe) strobes++;
            if (done) dones++;
            if (i == 12) checkOutput("plan2_wrap", 16'h1000, 8'd0, 1'b1, 1'b1, 1'b0);
        end
        checkCount("plan2_strobes", strobes, 12);
        checkCount("plan2_dones", dones, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0); cycle();

        // Single-step song at full speed, with a live rewrite of step 0.
        tempo_div = 24'd0; song_len = 8'd0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0); cycle();
        for (int i = 0; i < 4; i++) begin
            idleCycle();
            checkOutput("plan5_every_cycle", 16'h1000, 8'd0, 1'b1, 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'd0, 16'hABCD); cycle();
        checkOutput("plan5_old_word", 16'h1000, 8'd0, 1'b1, 1'b1, 1'b0);
        idleCycle();
        checkOutput("plan5_new_word", 16'hABCD, 8'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0); cycle();

        // Asynchronous reset in the middle of a song; memory must survive.
        tempo_div = 24'd2; song_len = 8'd3; loop_en = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0); cycle();
        for (int i = 0; i < 4; i++) idleCycle();
        #1 reset = 1'b1;
        #1;
        modelReset();
        checkOutput("plan6_async_reset", '0, '0, 1'b0, 1'b0, 1'b0);
        cycle();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0); cycle();
        checkOutput("plan6_restart", 16'hABCD, 8'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0); cycle();

        // Randomized run against the model, with live song_len changes.
        for (int i = 0; i < 1500; i++) begin
            if (ref_mode == 0 && ($urandom % 8) == 0) begin
                tempo_div = 24'($urandom_range(0, 3));
                loop_en   = 1'($urandom % 2);
            end
            if (($urandom % 30) == 0) song_len = 8'($urandom_range(0, 7));
            applyStimulus(($urandom % 10) == 0, ($urandom % 50) == 0, ($urandom % 5) == 0,
                          8'($urandom_range(0, 15)), 16'($urandom));
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
